buffer_reader: RTL and testbench

Memory-side reader paired with the buffer sync manager. On a trigger, it requests the newest completed buffer by raising `SM_request`, then latches the returned `SM_read_buffer` base address. It reads 2^`SM_log_length` words from DDR over an AXI4 read channel using bursts and streams them out on AXI4-Stream, marking the frame end with `tlast`. It feeds the DMA/host-export path, either one frame per trigger or back-to-back in continuous mode.

---
 rtl/buffer_reader.sv | 160 ++++++++++++++++
 tb/tb_buffer_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_reader.sv
// Fetches one 2^len_log-word frame from DDR in INCR bursts of up to 2^MAX_BURST_LOG beats after a
// sync-manager buffer request, and passes the R channel straight through onto AXI4-Stream.
module buffer_reader #(
   parameter int MM_ADDR_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_BURST_LOG = 4
) (
   input  logic                     SYS_aclk,
   input  logic                     SYS_areset,
   input  logic                     BR_trigger,
   input  logic                     BR_continuous,
   output logic                     BR_busy,
   output logic                     BR_done,
   output logic                     BR_error,
   output logic [31:0]              BR_frame_count,
   output logic                     SM_request,
   input  logic [4:0]               SM_log_length,
   input  logic [MM_ADDR_WIDTH-1:0] SM_read_buffer,
   output logic [MM_ADDR_WIDTH-1:0] M_AXI_araddr,
   output logic [7:0]               M_AXI_arlen,
   output logic [2:0]               M_AXI_arsize,
   output logic [1:0]               M_AXI_arburst,
   output logic                     M_AXI_arvalid,
   input  logic                     M_AXI_arready,
   input  logic [DATA_WIDTH-1:0]    M_AXI_rdata,
   input  logic [1:0]               M_AXI_rresp,
   input  logic                     M_AXI_rlast,
   input  logic                     M_AXI_rvalid,
   output logic                     M_AXI_rready,
   output logic [DATA_WIDTH-1:0]    M_AXIS_tdata,
   output logic                     M_AXIS_tvalid,
   input  logic                     M_AXIS_tready,
   output logic                     M_AXIS_tlast
);
   localparam int BYTE_LOG = $clog2(DATA_WIDTH / 8);

   typedef enum logic [2:0] {S_IDLE, S_REQUEST, S_LATCH, S_ADDR, S_DATA} state_t;

   state_t                   state_q, state_d;
   logic [4:0]               len_log_q, len_log_d;
   logic [MM_ADDR_WIDTH-1:0] base_q, base_d;
   logic [22:0]              beat_q, beat_d;
   logic [22:0]              burst_idx_q, burst_idx_d;
   logic                     err_q, err_d;
   logic [31:0]              frame_cnt_q, frame_cnt_d;

   logic [4:0]               blen_log;
   logic [22:0]              blen_m1;
   logic [22:0]              frame_m1;
   logic [MM_ADDR_WIDTH-1:0] burst_off;
   logic                     burst_end;
   logic                     frame_end;

   // Bursts never exceed the frame, so short frames become a single burst.
   always_comb begin
      blen_log  = (len_log_q > 5'(MAX_BURST_LOG)) ? 5'(MAX_BURST_LOG) : len_log_q;
      blen_m1   = (23'd1 << blen_log) - 23'd1;
      frame_m1  = (23'd1 << len_log_q) - 23'd1;
      burst_off = MM_ADDR_WIDTH'(burst_idx_q) << (blen_log + 5'(BYTE_LOG));
      burst_end = (beat_q & blen_m1) == blen_m1;
      frame_end = beat_q == frame_m1;
   end

   assign M_AXI_arlen    = 8'(blen_m1);
   assign M_AXI_arsize   = 3'(BYTE_LOG);
   assign M_AXI_arburst  = 2'b01;
   assign BR_busy        = state_q != S_IDLE;
   assign BR_error       = err_q;
   assign BR_frame_count = frame_cnt_q;

   always_comb begin
      state_d       = state_q;
      len_log_d     = len_log_q;
      base_d        = base_q;
      beat_d        = beat_q;
      burst_idx_d   = burst_idx_q;
      err_d         = err_q;
      frame_cnt_d   = frame_cnt_q;
      SM_request    = 1'b0;
      M_AXI_arvalid = 1'b0;
      M_AXI_araddr  = '0;
      M_AXI_rready  = 1'b0;
      M_AXIS_tvalid = 1'b0;
      M_AXIS_tdata  = '0;
      M_AXIS_tlast  = 1'b0;
      BR_done       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (BR_trigger || BR_continuous) begin
               state_d     = S_REQUEST;
               len_log_d   = SM_log_length;
               err_d       = 1'b0;
               beat_d      = '0;
               burst_idx_d = '0;
            end
         end
         S_REQUEST: begin
            SM_request = 1'b1;
            state_d    = S_LATCH;
         end
         // Holding the request high keeps the sync manager locked, so only one swap per frame.
         S_LATCH: begin
            SM_request = 1'b1;
            base_d     = SM_read_buffer;
            state_d    = S_ADDR;
         end
         S_ADDR: begin
            M_AXI_arvalid = 1'b1;
            M_AXI_araddr  = base_q + burst_off;
            if (M_AXI_arready) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            M_AXIS_tvalid = M_AXI_rvalid;
            M_AXIS_tdata  = M_AXI_rdata;
            M_AXIS_tlast  = frame_end && M_AXI_rvalid;
            M_AXI_rready  = M_AXIS_tready;
            if (M_AXI_rvalid && M_AXIS_tready) begin
               beat_d = beat_q + 23'd1;
               if ((M_AXI_rresp != 2'b00) || (M_AXI_rlast != burst_end)) begin
                  err_d = 1'b1;
               end
               // Burst boundaries come from the beat count; rlast is only cross-checked.
               if (burst_end) begin
                  if (frame_end) begin
                     BR_done     = 1'b1;
                     frame_cnt_d = frame_cnt_q + 32'd1;
                     state_d     = S_IDLE;
                  end else begin
                     burst_idx_d = burst_idx_q + 23'd1;
                     state_d     = S_ADDR;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge SYS_aclk) begin
      if (SYS_areset) begin
         state_q     <= S_IDLE;
         len_log_q   <= '0;
         base_q      <= '0;
         beat_q      <= '0;
         burst_idx_q <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         len_log_q   <= len_log_d;
         base_q      <= base_d;
         beat_q      <= beat_d;
         burst_idx_q <= burst_idx_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end
endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: AXI read slave with a synthetic memory, stream sink, and a frame-level
// expectation model (word list + burst list per frame) checked every cycle.
module tb_buffer_reader;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MBL = 4;

   logic          clk = 1'b0;
   logic          SYS_areset, BR_trigger, BR_continuous;
   logic          BR_busy, BR_done, BR_error;
   logic [31:0]   BR_frame_count;
   logic          SM_request;
   logic [4:0]    SM_log_length;
   logic [AW-1:0] SM_read_buffer;
   logic [AW-1:0] M_AXI_araddr;
   logic [7:0]    M_AXI_arlen;
   logic [2:0]    M_AXI_arsize;
   logic [1:0]    M_AXI_arburst;
   logic          M_AXI_arvalid, M_AXI_arready;
   logic [DW-1:0] M_AXI_rdata;
   logic [1:0]    M_AXI_rresp;
   logic          M_AXI_rlast, M_AXI_rvalid, M_AXI_rready;
   logic [DW-1:0] M_AXIS_tdata;
   logic          M_AXIS_tvalid, M_AXIS_tready, M_AXIS_tlast;

   always #5 clk = ~clk;

   buffer_reader #(.MM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LOG(MBL)) dut (
      .SYS_aclk(clk), .SYS_areset(SYS_areset), .BR_trigger(BR_trigger), .BR_continuous(BR_continuous),
      .BR_busy(BR_busy), .BR_done(BR_done), .BR_error(BR_error), .BR_frame_count(BR_frame_count),
      .SM_request(SM_request), .SM_log_length(SM_log_length), .SM_read_buffer(SM_read_buffer),
      .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arsize(M_AXI_arsize),
      .M_AXI_arburst(M_AXI_arburst), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
      .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rlast(M_AXI_rlast),
      .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready), .M_AXIS_tdata(M_AXIS_tdata),
      .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tlast(M_AXIS_tlast)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed { logic [DW-1:0] dat; logic last; logic bend; } beat_t;
   typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } ar_t;

   beat_t exp_beats[$];
   ar_t   exp_ars[$];

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   // A frame is 2^lg consecutive words from base, fetched as bursts of min(2^lg, 2^MBL) words.
   task automatic expect_frame(input logic [AW-1:0] base, input int lg);
      beat_t b;
      ar_t   r;
      int    n;
      int    bl;
      n  = 1 << lg;
      bl = 1 << ((lg < MBL) ? lg : MBL);
      for (int i = 0; i < n; i++) begin
         b.dat  = mem_word(base + AW'(4 * i));
         b.last = (i == n - 1);
         b.bend = ((i % bl) == bl - 1);
         exp_beats.push_back(b);
      end
      for (int k = 0; k < n / bl; k++) begin
         r.addr = base + AW'(k * bl * 4);
         r.len  = 8'(bl - 1);
         exp_ars.push_back(r);
      end
   endtask

   // AXI read slave: one burst at a time, optional AR delay and an error-injection address.
   int            ar_delay = 0;
   logic [AW-1:0] err_addr = '1;
   initial begin : slave
      logic [AW-1:0] a;
      int            len;
      M_AXI_arready = 1'b0;
      M_AXI_rvalid  = 1'b0;
      M_AXI_rdata   = '0;
      M_AXI_rresp   = 2'b00;
      M_AXI_rlast   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (M_AXI_arvalid && !SYS_areset) begin
            for (int d = 0; d < ar_delay; d++) begin
               @(posedge clk); #1;
            end
            a             = M_AXI_araddr;
            len           = int'(M_AXI_arlen);
            M_AXI_arready = 1'b1;
            @(posedge clk); #1;
            M_AXI_arready = 1'b0;
            for (int b = 0; b <= len; b++) begin
               M_AXI_rvalid = 1'b1;
               M_AXI_rdata  = mem_word(a + AW'(4 * b));
               M_AXI_rresp  = ((a + AW'(4 * b)) == err_addr) ? 2'b10 : 2'b00;
               M_AXI_rlast  = (b == len);
               do @(negedge clk); while (!M_AXI_rready && !SYS_areset);
               if (SYS_areset) break;
               @(posedge clk); #1;
            end
            M_AXI_rvalid = 1'b0;
            M_AXI_rresp  = 2'b00;
            M_AXI_rlast  = 1'b0;
         end
      end
   end

   int tready_mode = 0;
   initial begin
      M_AXIS_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         M_AXIS_tready = (tready_mode == 0) ? 1'b1 : ~M_AXIS_tready;
      end
   end

   // Per-cycle comparison against the frame model.
   logic          m_err    = 1'b0;
   logic [31:0]   m_cnt    = '0;
   logic          prev_req = 1'b0;
   logic          ar_pend  = 1'b0;
   logic [AW-1:0] ar_paddr = '0;
   logic [7:0]    ar_plen  = '0;
   int            ar_hs    = 0;
   int            n_tlast  = 0;

   always @(negedge clk) begin
      beat_t b;
      ar_t   r;
      logic  exp_done;
      if (SYS_areset) begin
         exp_beats.delete();
         exp_ars.delete();
         m_err    = 1'b0;
         m_cnt    = '0;
         prev_req = 1'b0;
         ar_pend  = 1'b0;
      end else begin
         if (SM_request && !prev_req) m_err = 1'b0;
         prev_req = SM_request;
         check("error_flag", BR_error, m_err);
         check("frame_count", BR_frame_count, m_cnt);
         if (ar_pend) begin
            check("ar_hold_valid", M_AXI_arvalid, 1);
            check("ar_hold_addr", M_AXI_araddr, ar_paddr);
            check("ar_hold_len", M_AXI_arlen, ar_plen);
         end
         ar_pend  = M_AXI_arvalid && !M_AXI_arready;
         ar_paddr = M_AXI_araddr;
         ar_plen  = M_AXI_arlen;
         if (M_AXI_arvalid && M_AXI_arready) begin
            ar_hs++;
            if (exp_ars.size() == 0) begin
               check("unexpected_ar", 1, 0);
            end else begin
               r = exp_ars.pop_front();
               check("araddr", M_AXI_araddr, r.addr);
               check("arlen", M_AXI_arlen, r.len);
               check("arsize", M_AXI_arsize, 3'd2);
               check("arburst", M_AXI_arburst, 2'b01);
            end
         end
         check("tvalid_follows_rvalid", M_AXIS_tvalid, M_AXI_rvalid);
         if (M_AXI_rvalid) begin
            check("rready_follows_tready", M_AXI_rready, M_AXIS_tready);
            check("tdata_follows_rdata", M_AXIS_tdata, M_AXI_rdata);
         end else begin
            check("tlast_idle", M_AXIS_tlast, 0);
         end
         exp_done = 1'b0;
         if (M_AXIS_tvalid && M_AXIS_tready) begin
            if (M_AXIS_tlast) n_tlast++;
            if (exp_beats.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               b = exp_beats.pop_front();
               check("tdata", M_AXIS_tdata, b.dat);
               check("tlast", M_AXIS_tlast, b.last);
               exp_done = b.last;
               if ((M_AXI_rresp != 2'b00) || (M_AXI_rlast != b.bend)) m_err = 1'b1;
            end
         end
         check("done_pulse", BR_done, exp_done);
         if (exp_done) m_cnt = m_cnt + 32'd1;
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input string nm);
      int c;
      c = 0;
      while (c < 3000) begin
         @(negedge clk);
         if (BR_done) break;
         c++;
      end
      check({nm, "_done_seen"}, (c < 3000), 1);
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_req"}, SM_request, 0);
      check({nm, "_arvalid"}, M_AXI_arvalid, 0);
      check({nm, "_araddr"}, M_AXI_araddr, 0);
      check({nm, "_rready"}, M_AXI_rready, 0);
      check({nm, "_tvalid"}, M_AXIS_tvalid, 0);
      check({nm, "_tlast"}, M_AXIS_tlast, 0);
      check({nm, "_tdata"}, M_AXIS_tdata, 0);
      check({nm, "_busy"}, BR_busy, 0);
      check({nm, "_done"}, BR_done, 0);
      check({nm, "_error"}, BR_error, 0);
      check({nm, "_count"}, BR_frame_count, 0);
   endtask

   // One triggered frame, entered and left just after a rising edge. The lit_* arguments are
   // hand-computed expectations for this particular frame.
   task automatic run_frame(input string nm, input logic [AW-1:0] base, input logic [4:0] lg,
                            input logic [7:0] lit_arlen, input int lit_bursts,
                            input logic [31:0] lit_count, input bit retrig);
      int ar0;
      int tl0;
      ar0            = ar_hs;
      tl0            = n_tlast;
      SM_read_buffer = base;
      SM_log_length  = lg;
      expect_frame(base, int'(lg));
      BR_trigger = 1'b1;
      tick();
      BR_trigger    = 1'b0;
      SM_log_length = lg + 5'd1;
      @(negedge clk);
      check({nm, "_c1_req"}, SM_request, 1);
      check({nm, "_c1_arvalid"}, M_AXI_arvalid, 0);
      check({nm, "_c1_error_clear"}, BR_error, 0);
      @(negedge clk);
      check({nm, "_c2_req"}, SM_request, 1);
      tick();
      SM_read_buffer = ~base;
      @(negedge clk);
      check({nm, "_c3_req"}, SM_request, 0);
      check({nm, "_c3_arvalid"}, M_AXI_arvalid, 1);
      check({nm, "_c3_araddr"}, M_AXI_araddr, base);
      check({nm, "_c3_arlen"}, M_AXI_arlen, lit_arlen);
      if (retrig) begin
         tick();
         BR_trigger = 1'b1;
         tick();
         BR_trigger = 1'b0;
      end
      wait_done(nm);
      @(negedge clk);
      check({nm, "_idle_busy"}, BR_busy, 0);
      check({nm, "_count"}, BR_frame_count, lit_count);
      check({nm, "_bursts"}, ar_hs - ar0, lit_bursts);
      check({nm, "_tlasts"}, n_tlast - tl0, 1);
      check({nm, "_drained"}, exp_beats.size(), 0);
      tick();
   endtask

   initial begin
      int c;
      SYS_areset     = 1'b1;
      BR_trigger     = 1'b0;
      BR_continuous  = 1'b0;
      SM_log_length  = 5'd0;
      SM_read_buffer = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      tick();
      SYS_areset = 1'b0;
      tick();

      run_frame("len16", 32'h1000_0040, 5'd4, 8'd15, 1, 32'd1, 1'b0);
      run_frame("len64", 32'h2000_0000, 5'd6, 8'd15, 4, 32'd2, 1'b0);
      run_frame("len4", 32'h0000_0100, 5'd2, 8'd3, 1, 32'd3, 1'b0);
      run_frame("len1", 32'h0000_0300, 5'd0, 8'd0, 1, 32'd4, 1'b0);

      ar_delay    = 5;
      tready_mode = 1;
      run_frame("stall", 32'h0000_8000, 5'd4, 8'd15, 1, 32'd5, 1'b0);
      ar_delay    = 0;
      tready_mode = 0;

      err_addr = 32'h0000_9008;
      run_frame("rresp", 32'h0000_9000, 5'd4, 8'd15, 1, 32'd6, 1'b0);
      check("rresp_sticky", BR_error, 1);
      err_addr = '1;
      run_frame("clear", 32'h0000_9000, 5'd3, 8'd7, 1, 32'd7, 1'b0);
      check("clear_error", BR_error, 0);

      run_frame("retrig", 32'h0000_A000, 5'd5, 8'd15, 2, 32'd8, 1'b1);
      repeat (4) @(negedge clk);
      check("retrig_stays_idle", BR_busy, 0);

      tick();
      SM_read_buffer = 32'h0000_B000;
      SM_log_length  = 5'd2;
      expect_frame(32'h0000_B000, 2);
      expect_frame(32'h0000_B000, 2);
      BR_continuous = 1'b1;
      wait_done("cont1");
      @(negedge clk);
      check("cont_gap_busy", BR_busy, 0);
      check("cont_gap_req", SM_request, 0);
      @(negedge clk);
      check("cont_next_req", SM_request, 1);
      tick();
      BR_continuous = 1'b0;
      wait_done("cont2");
      @(negedge clk);
      check("cont_count", BR_frame_count, 32'd10);
      repeat (3) @(negedge clk);
      check("cont_stopped", BR_busy, 0);

      tick();
      SM_read_buffer = 32'h4000_0000;
      SM_log_length  = 5'd4;
      expect_frame(32'h4000_0000, 4);
      BR_trigger = 1'b1;
      tick();
      BR_trigger = 1'b0;
      c = 0;
      while (exp_beats.size() > 10 && c < 500) begin
         @(negedge clk);
         c++;
      end
      check("rst_reached_data", (c < 500), 1);
      tick();
      SYS_areset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("midrst");
      tick();
      SYS_areset = 1'b0;
      tick();
      run_frame("recover", 32'h0000_C000, 5'd1, 8'd1, 1, 32'd1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end
endmodule
